band_level_meter: RTL

//  Downstream of SystolicFilter: takes each filtered 16-bit signed sample and drives one
//  bar column of the RainbowMatrix display.
//  - Rectifies each sample and tracks a peak envelope: instant attack, exponential decay.
//  - Once per display frame of UPDATE_SAMPLES samples, quantises the frame's max envelope
//    to a log2 bar height 0..ROWS.
//  - Maintains a falling peak-hold marker.

---
 rtl/band_level_meter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/band_level_meter.sv
// Per-column level meter: rectify, peak-envelope follower, per-frame log2 bar height
// and a falling peak-hold marker for one display column.
module band_level_meter #(
    parameter int ROWS           = 8,
    parameter int LEVEL_W        = 4,
    parameter int DECAY_SHIFT    = 4,
    parameter int UPDATE_SAMPLES = 512,
    parameter int HOLD_FRAMES    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic [15:0]        sample_in,
    input  logic               clear,
    output logic [14:0]        envelope,
    output logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] peak_level,
    output logic               level_valid
);

    localparam int          CNT_W    = (UPDATE_SAMPLES > 1) ? $clog2(UPDATE_SAMPLES) : 1;
    localparam int          HOLD_W   = $clog2(HOLD_FRAMES + 1);
    localparam int          Q_OFFSET = 14 - ROWS;
    localparam logic [14:0] Q_MIN    = 15'(1 << (15 - ROWS));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_SAMPLES - 1);

    // Strobe semantics: sample_valid is a one-cycle qualifier with no ready/backpressure;
    // every strobe is consumed, and level_valid is a one-cycle pulse with no acknowledge.

    logic [14:0]        abs_q, abs_d;
    logic               abs_v_q, abs_v_d;
    logic [14:0]        env_q, env_d;
    logic [14:0]        fmax_q, fmax_d;
    logic [14:0]        close_max_q, close_max_d;
    logic               close_q, close_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] peak_q, peak_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               lvl_v_q, lvl_v_d;

    logic [14:0]        mag;
    logic [15:0]        neg;
    logic [14:0]        decay;
    logic [14:0]        env_max;
    logic [LEVEL_W-1:0] new_lvl;
    logic [LEVEL_W-1:0] peak_dec;

    function automatic logic [LEVEL_W-1:0] quantise(input logic [14:0] x);
        logic [3:0] msb;
        msb = '0;
        for (int i = 0; i < 15; i++) begin
            if (x[i]) msb = 4'(i);
        end
        if (x < Q_MIN) return '0;
        else if (int'(msb) - Q_OFFSET >= ROWS) return LEVEL_W'(ROWS);
        else return LEVEL_W'(int'(msb) - Q_OFFSET);
    endfunction

    // -32768 has no 15-bit magnitude, so it saturates to full scale.
    always_comb begin
        neg = 16'(~sample_in + 16'd1);
        if (!sample_in[15])              mag = sample_in[14:0];
        else if (sample_in == 16'h8000)  mag = 15'h7fff;
        else                             mag = neg[14:0];
    end

    assign decay    = env_q >> DECAY_SHIFT;
    assign env_max  = (fmax_q > env_d) ? fmax_q : env_d;
    assign new_lvl  = quantise(close_max_q);
    assign peak_dec = peak_q - LEVEL_W'(1);

    always_comb begin
        abs_d       = abs_q;
        abs_v_d     = 1'b0;
        env_d       = env_q;
        fmax_d      = fmax_q;
        close_max_d = close_max_q;
        close_d     = 1'b0;
        cnt_d       = cnt_q;
        level_d     = level_q;
        peak_d      = peak_q;
        hold_d      = hold_q;
        lvl_v_d     = 1'b0;

        if (sample_valid) begin
            abs_d   = mag;
            abs_v_d = 1'b1;
        end

        if (abs_v_q) begin
            // The final -1 step guarantees the envelope settles at exactly zero.
            if (abs_q > env_q)      env_d = abs_q;
            else if (decay != '0)   env_d = env_q - decay;
            else if (env_q != '0)   env_d = env_q - 15'd1;
            else                    env_d = '0;
        end

        // env_max depends on env_d, so the frame bookkeeping follows the envelope update.
        if (abs_v_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                close_d     = 1'b1;
                close_max_d = env_max;
                fmax_d      = '0;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                fmax_d = env_max;
            end
        end

        if (close_q) begin
            level_d = new_lvl;
            lvl_v_d = 1'b1;
            if (new_lvl >= peak_q) begin
                peak_d = new_lvl;
                hold_d = HOLD_W'(HOLD_FRAMES);
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end else begin
                peak_d = (new_lvl > peak_dec) ? new_lvl : peak_dec;
            end
        end

        if (clear) begin
            abs_d       = '0;
            abs_v_d     = 1'b0;
            env_d       = '0;
            fmax_d      = '0;
            close_max_d = '0;
            close_d     = 1'b0;
            cnt_d       = '0;
            level_d     = '0;
            peak_d      = '0;
            hold_d      = '0;
            lvl_v_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_q       <= '0;
            abs_v_q     <= 1'b0;
            env_q       <= '0;
            fmax_q      <= '0;
            close_max_q <= '0;
            close_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= '0;
            peak_q      <= '0;
            hold_q      <= '0;
            lvl_v_q     <= 1'b0;
        end else begin
            abs_q       <= abs_d;
            abs_v_q     <= abs_v_d;
            env_q       <= env_d;
            fmax_q      <= fmax_d;
            close_max_q <= close_max_d;
            close_q     <= close_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            peak_q      <= peak_d;
            hold_q      <= hold_d;
            lvl_v_q     <= lvl_v_d;
        end
    end

    assign envelope    = env_q;
    assign level       = level_q;
    assign peak_level  = peak_q;
    assign level_valid = lvl_v_q;

endmodule
